// File: rtl/branch_resolve_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_pkg
// Description : Shared types and constants for the decode-stage branch
//               resolution unit (FSM states, link register, PC offsets).
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_pkg;

   // Resolution FSM states
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_SLOT = 2'd1,
      ST_REDIRECT  = 2'd2
   } br_state_t;

   // Architectural link register used by JAL/BLTZAL/BGEZAL
   localparam logic [4:0] LINK_REG = 5'd31;

   // Offset from a CTI to its delay slot (branch base) and past it (link value)
   localparam int unsigned SLOT_PC_OFFSET = 4;
   localparam int unsigned LINK_PC_OFFSET = 8;

endpackage : branch_resolve_pkg
`default_nettype wire

// File: rtl/branch_resolve_cond.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_cond
// Description : Combinational branch condition (signed compare) and
//               control-transfer target selection.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_cond
   import branch_resolve_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_pc,
   input  logic [25:0]     i_index,
   input  logic            i_jump,
   input  logic            i_branch,
   input  logic            i_lt,
   input  logic            i_gt,
   input  logic            i_eq,
   input  logic            i_src,
   input  logic [XLEN-1:0] i_rs_val,
   input  logic [XLEN-1:0] i_rt_val,
   output logic            o_taken,
   output logic [XLEN-1:0] o_target
);

   logic [XLEN-1:0] w_b;
   logic [XLEN-1:0] w_pc4;
   logic [XLEN-1:0] w_br_off;
   logic            w_cond;

   // Second compare operand is rt for two-register branches, zero otherwise
   assign w_b      = i_src ? i_rt_val : '0;
   assign w_pc4    = i_pc + XLEN'(SLOT_PC_OFFSET);
   assign w_br_off = {{(XLEN-18){i_index[15]}}, i_index[15:0], 2'b00};

   // Signed relational evaluation; any enabled relation that holds takes it
   always_comb begin
      w_cond = (i_lt & ($signed(i_rs_val) <  $signed(w_b))) |
               (i_gt & ($signed(i_rs_val) >  $signed(w_b))) |
               (i_eq & (i_rs_val == w_b));
      o_taken = i_jump | (i_branch & w_cond);
   end

   // Target selection: register jump, region jump, or PC-relative branch
   always_comb begin
      o_target = w_pc4 + w_br_off;
      if (i_jump) begin
         if (i_src) begin
            o_target = i_rs_val;
         end else begin
            o_target = {w_pc4[XLEN-1:28], i_index, 2'b00};
         end
      end
   end

endmodule : branch_resolve_cond
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Decode-stage branch resolution with single delay slot,
//               held redirect handshake to fetch, link write and taken count.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  pc,
   input  logic [31:0]      instr,
   input  logic             jump,
   input  logic             branch,
   input  logic             lt,
   input  logic             gt,
   input  logic             eq,
   input  logic             src,
   input  logic             link,
   input  logic [XLEN-1:0]  rs_val,
   input  logic [XLEN-1:0]  rt_val,
   output logic             redirect_valid,
   input  logic             redirect_ready,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             link_we,
   output logic [4:0]       link_addr,
   output logic [XLEN-1:0]  link_data,
   output logic             err_slot_cti,
   output logic [CNT_W-1:0] taken_cnt
);

   br_state_t        r_state;
   br_state_t        w_state_nxt;
   logic [XLEN-1:0]  r_target;
   logic [CNT_W-1:0] r_cnt;
   logic             r_link_we;
   logic [4:0]       r_link_addr;
   logic [XLEN-1:0]  r_link_data;
   logic             r_err;

   logic             w_accept;
   logic             w_cti;
   logic             w_taken;
   logic [XLEN-1:0]  w_target;
   logic             w_take;
   logic             w_link_fire;
   logic             w_slot_err;
   logic             w_unused;

   // Opcode field is fully decoded upstream
   assign w_unused = ^instr[31:26];

   assign w_cti    = jump | branch;
   assign in_ready = (r_state != ST_REDIRECT);
   assign w_accept = in_valid & in_ready;

   branch_resolve_cond #(
      .XLEN (XLEN)
   ) u_cond (
      .i_pc     (pc),
      .i_index  (instr[25:0]),
      .i_jump   (jump),
      .i_branch (branch),
      .i_lt     (lt),
      .i_gt     (gt),
      .i_eq     (eq),
      .i_src    (src),
      .i_rs_val (rs_val),
      .i_rt_val (rt_val),
      .o_taken  (w_taken),
      .o_target (w_target)
   );

   // Next-state and per-acceptance strobes; a CTI in the delay slot is inert
   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_link_fire = 1'b0;
      w_slot_err  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_link_fire = link;
               if (w_taken) begin
                  w_take      = 1'b1;
                  w_state_nxt = ST_WAIT_SLOT;
               end
            end
         end
         ST_WAIT_SLOT: begin
            if (w_accept) begin
               w_state_nxt = ST_REDIRECT;
               if (w_cti) begin
                  w_slot_err = 1'b1;
               end else begin
                  w_link_fire = link;
               end
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, target latch and taken counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_target <= '0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_take) begin
            r_target <= w_target;
            r_cnt    <= r_cnt + 1'b1;
         end
      end
   end

   // Link write stage and slot-error pulse, one cycle after acceptance
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_link_we   <= 1'b0;
         r_link_addr <= '0;
         r_link_data <= '0;
         r_err       <= 1'b0;
      end else begin
         r_link_we <= w_link_fire;
         r_err     <= w_slot_err;
         if (w_link_fire) begin
            r_link_addr <= (jump & src) ? instr[15:11] : LINK_REG;
            r_link_data <= pc + XLEN'(LINK_PC_OFFSET);
         end
      end
   end

   // Redirect is state-decoded so an asynchronous reset drops it at once
   assign redirect_valid = (r_state == ST_REDIRECT);
   assign redirect_pc    = r_target;
   assign link_we        = r_link_we;
   assign link_addr      = r_link_addr;
   assign link_data      = r_link_data;
   assign err_slot_cti   = r_err;
   assign taken_cnt      = r_cnt;

endmodule : branch_resolve
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve
// Description : Directed stimulus with scoreboard queues for redirect, link
//               and slot-error events; monitor pops on DUT output activity.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        jump, branch, lt, gt, eq, src, link;
   logic [31:0] rs_val, rt_val;
   logic        redirect_valid;
   logic        redirect_ready;
   logic [31:0] redirect_pc;
   logic        link_we;
   logic [4:0]  link_addr;
   logic [31:0] link_data;
   logic        err_slot_cti;
   logic [31:0] taken_cnt;

   int errors = 0;
   int checks = 0;

   logic [31:0] q_redir[$];
   logic [36:0] q_link[$];
   int          q_err[$];

   branch_resolve #(.XLEN(32), .CNT_W(32)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .pc             (pc),
      .instr          (instr),
      .jump           (jump),
      .branch         (branch),
      .lt             (lt),
      .gt             (gt),
      .eq             (eq),
      .src            (src),
      .link           (link),
      .rs_val         (rs_val),
      .rt_val         (rt_val),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .redirect_pc    (redirect_pc),
      .link_we        (link_we),
      .link_addr      (link_addr),
      .link_data      (link_data),
      .err_slot_cti   (err_slot_cti),
      .taken_cnt      (taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] i_pc, input logic [31:0] i_instr,
                        input logic j, input logic b, input logic l, input logic g,
                        input logic e, input logic s, input logic k,
                        input logic [31:0] rs, input logic [31:0] rt);
      pc = i_pc; instr = i_instr;
      jump = j; branch = b; lt = l; gt = g; eq = e; src = s; link = k;
      rs_val = rs; rt_val = rt;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      {jump, branch, lt, gt, eq, src, link} = '0;
   endtask

   task automatic slot(input logic [31:0] i_pc);
      issue(i_pc, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
   endtask

   // Monitor: compare every DUT output event against the scoreboard
   always @(negedge clk) begin
      if (reset_n) begin
         if (redirect_valid && redirect_ready) begin
            if (q_redir.size() == 0) begin
               chk("redir_unexpected", {32'h0, redirect_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               chk("redirect_pc", {32'h0, redirect_pc}, {32'h0, q_redir.pop_front()});
            end
         end
         if (link_we) begin
            if (q_link.size() == 0) begin
               chk("link_unexpected", {27'h0, link_addr, link_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               chk("link_addr_data", {27'h0, link_addr, link_data}, {27'h0, q_link.pop_front()});
            end
         end
         if (err_slot_cti) begin
            if (q_err.size() == 0) begin
               chk("err_unexpected", 64'h1, 64'h0);
            end else begin
               void'(q_err.pop_front());
               chk("err_slot_cti", {63'h0, err_slot_cti}, 64'h1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; redirect_ready = 1'b1;
      pc = '0; instr = '0; rs_val = '0; rt_val = '0;
      {jump, branch, lt, gt, eq, src, link} = '0;
      tick(); tick();
      chk("rst_redirect_valid", {63'h0, redirect_valid}, 64'h0);
      chk("rst_outputs", {link_we, err_slot_cti, link_addr, redirect_pc}, 64'h0);
      chk("rst_link_data", {32'h0, link_data}, 64'h0);
      chk("rst_taken_cnt", {32'h0, taken_cnt}, 64'h0);
      chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
      reset_n = 1'b1;
      tick();

      // BEQ taken, slot in next cycle, zero-bubble redirect
      q_redir.push_back(32'h0000_0114);
      issue(32'h100, {6'h04, 5'd1, 5'd2, 16'h0004}, 0, 1, 0, 0, 1, 1, 0, 32'd5, 32'd5);
      chk("beq_cnt", {32'h0, taken_cnt}, 64'd1);
      chk("beq_ready_wait", {63'h0, in_ready}, 64'h1);
      slot(32'h104);
      chk("beq_redir_latency", {63'h0, redirect_valid}, 64'h1);
      chk("beq_ready_redir", {63'h0, in_ready}, 64'h0);
      tick();
      chk("beq_redir_drop", {63'h0, redirect_valid}, 64'h0);

      // BNE with equal operands: not taken
      issue(32'h200, {6'h05, 5'd1, 5'd2, 16'h0008}, 0, 1, 1, 1, 0, 1, 0, 32'd7, 32'd7);
      chk("bne_ready", {63'h0, in_ready}, 64'h1);
      chk("bne_cnt", {32'h0, taken_cnt}, 64'd1);
      tick();
      chk("bne_no_redir", {63'h0, redirect_valid}, 64'h0);

      // JAL region jumps with link
      q_link.push_back({5'd31, 32'h0040_0008});
      q_redir.push_back(32'h0040_0000);
      issue(32'h0040_0000, {6'h03, 26'h0100000}, 1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
      slot(32'h0040_0004);
      tick();
      q_link.push_back({5'd31, 32'h0040_0008});
      q_redir.push_back(32'h0000_0040);
      issue(32'h0040_0000, {6'h03, 26'h0000010}, 1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
      slot(32'h0040_0004);
      tick();
      chk("jal_cnt", {32'h0, taken_cnt}, 64'd3);

      // BLTZAL not taken still links
      q_link.push_back({5'd31, 32'h0000_0308});
      issue(32'h300, {6'h01, 5'd1, 5'h10, 16'h0010}, 0, 1, 1, 0, 0, 0, 1, 32'h1, 32'h0);
      tick();
      chk("bltzal_nt_cnt", {32'h0, taken_cnt}, 64'd3);
      chk("bltzal_nt_redir", {63'h0, redirect_valid}, 64'h0);

      // BLTZAL taken, long slot gap, stalled redirect
      q_link.push_back({5'd31, 32'h0000_0408});
      q_redir.push_back(32'h0000_0444);
      issue(32'h400, {6'h01, 5'd1, 5'h10, 16'h0010}, 0, 1, 1, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'h0);
      chk("bltzal_t_cnt", {32'h0, taken_cnt}, 64'd4);
      redirect_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("wait_slot_ready", {62'h0, in_ready, redirect_valid}, 64'h2);
      end
      slot(32'h404);
      for (int i = 0; i < 3; i++) begin
         chk("stall_hold", {31'h0, redirect_valid, in_ready, redirect_pc}, {32'h2, 32'h0000_0444});
         tick();
      end
      redirect_ready = 1'b1;
      tick();
      chk("stall_release", {62'h0, redirect_valid, in_ready}, 64'h1);

      // JR with a linking branch in its delay slot
      q_redir.push_back(32'h0000_1234);
      q_err.push_back(1);
      issue(32'h500, {6'h00, 5'd4, 15'h0, 6'h08}, 1, 0, 0, 0, 0, 1, 0, 32'h1234, 32'h0);
      issue(32'h504, {6'h01, 5'd1, 5'h11, 16'h0004}, 0, 1, 0, 1, 1, 0, 1, 32'd5, 32'd0);
      chk("jr_slot_err", {63'h0, err_slot_cti}, 64'h1);
      tick();
      chk("jr_cnt", {32'h0, taken_cnt}, 64'd5);
      chk("jr_err_pulse", {63'h0, err_slot_cti}, 64'h0);

      // JALR links to rd
      q_link.push_back({5'd3, 32'h0000_0808});
      q_redir.push_back(32'h0000_2000);
      issue(32'h800, {6'h00, 5'd4, 5'd0, 5'd3, 5'd0, 6'h09}, 1, 0, 0, 0, 0, 1, 1, 32'h2000, 32'h0);
      slot(32'h804);
      tick();
      chk("jalr_cnt", {32'h0, taken_cnt}, 64'd6);

      // Asynchronous reset while a redirect is pending
      redirect_ready = 1'b0;
      issue(32'h600, {6'h02, 26'h0000080}, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      slot(32'h604);
      chk("pre_rst_redir", {32'h1, redirect_pc}, {32'h1, 32'h0000_0200});
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_redir", {62'h0, redirect_valid, in_ready}, 64'h1);
      chk("async_rst_outs", {link_we, err_slot_cti, link_addr, redirect_pc}, 64'h0);
      chk("async_rst_cnt", {32'h0, taken_cnt}, 64'h0);
      tick();
      reset_n = 1'b1;
      redirect_ready = 1'b1;
      tick();

      // J after reset
      q_redir.push_back(32'h0000_0400);
      issue(32'h700, {6'h02, 26'h0000100}, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      slot(32'h704);
      chk("post_rst_redir", {63'h0, redirect_valid}, 64'h1);
      tick();
      tick();
      chk("post_rst_cnt", {32'h0, taken_cnt}, 64'd1);

      chk("q_redir_empty", 64'(q_redir.size()), 64'h0);
      chk("q_link_empty", 64'(q_link.size()), 64'h0);
      chk("q_err_empty", 64'(q_err.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_branch_resolve
`default_nettype wire
